// File: rtl/ngb_clk_pkg.sv
// Shared clocking package for the MMCM dynamic-reconfiguration controller.
//   drp_state_e  : controller FSM states
//   drp_entry_t  : one DRP register update {addr, mask, data}; mask bit 1 keeps the old bit
//   PROFILE0/1   : 8-entry register tables. Profile 0 is the current
//                  125/200/166/20/100 MHz set (VCO 1000 MHz); profile 1 is the alternate.
package ngb_clk_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RST_ON, ST_RD, ST_RD_WAIT, ST_WR, ST_WR_WAIT,
    ST_NEXT, ST_RST_OFF, ST_WAIT_LOCK, ST_FINISH
  } drp_state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  localparam int DRP_ENTRIES = 8;

  // ClkReg1 keeps its reserved bit 12; ClkReg2 keeps everything above the
  // edge/no-count/delay field.
  localparam logic [15:0] MASK_REG1 = 16'h1000;
  localparam logic [15:0] MASK_REG2 = 16'hFC00;

  // Entry order: CLKOUT0 reg1/reg2, CLKOUT1..4 reg1, CLKFBOUT reg1/reg2.
  // reg1 data = {high_time[11:6], low_time[5:0]}.
  localparam drp_entry_t [0:DRP_ENTRIES-1] PROFILE0 = '{
    {7'h08, MASK_REG1, 16'h0104},   // /8  -> 125 MHz
    {7'h09, MASK_REG2, 16'h0000},
    {7'h0A, MASK_REG1, 16'h00C2},   // /5  -> 200 MHz
    {7'h0C, MASK_REG1, 16'h00C3},   // /6  -> 166 MHz
    {7'h0E, MASK_REG1, 16'h0659},   // /50 -> 20 MHz
    {7'h10, MASK_REG1, 16'h0145},   // /10 -> 100 MHz
    {7'h14, MASK_REG1, 16'h0145},   // FB x10
    {7'h15, MASK_REG2, 16'h0000}
  };

  localparam drp_entry_t [0:DRP_ENTRIES-1] PROFILE1 = '{
    {7'h08, MASK_REG1, 16'h0145},   // /10 -> 100 MHz
    {7'h09, MASK_REG2, 16'h0000},
    {7'h0A, MASK_REG1, 16'h0082},   // /4  -> 250 MHz
    {7'h0C, MASK_REG1, 16'h0104},   // /8  -> 125 MHz
    {7'h0E, MASK_REG1, 16'h0514},   // /40 -> 25 MHz
    {7'h10, MASK_REG1, 16'h028A},   // /20 -> 50 MHz
    {7'h14, MASK_REG1, 16'h0145},   // FB x10
    {7'h15, MASK_REG2, 16'h0000}
  };

endpackage

// File: rtl/ngb_mmcm_drp_rom.sv
// Profile table lookup.
//   sel   : profile select
//   idx   : entry index 0..7
//   entry : {addr, mask, data} for that entry (combinational)
module ngb_mmcm_drp_rom
  import ngb_clk_pkg::*;
(
  input  logic       sel,
  input  logic [2:0] idx,
  output drp_entry_t entry
);

  always_comb entry = sel ? PROFILE1[idx] : PROFILE0[idx];

endmodule

// File: rtl/ngb_mmcm_drp_ctrl.sv
// MMCM reconfiguration controller: holds the MMCM in reset, read-modify-writes
// the 8 DRP registers of the selected profile, releases reset and waits for a
// qualified lock. Also produces lock_ok for the downstream reset chains.
//   clk_in, reset            : clock (also DCLK), synchronous active-high reset
//   cfg_req, cfg_sel         : request pulse and profile select
//   cfg_busy/done/err        : status; done and err pulse together on failure
//   drp_*                    : MMCM DRP port
//   mmcm_rst, mmcm_locked    : MMCM RST / LOCKED
//   lock_ok                  : LOCKED held high for LOCK_HOLD cycles
module ngb_mmcm_drp_ctrl
  import ngb_clk_pkg::*;
#(
  parameter int LOCK_HOLD    = 200,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cfg_req,
  input  logic        cfg_sel,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        lock_ok
);

  localparam int LCW  = $clog2(LOCK_HOLD) + 1;
  localparam int WMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int WCW  = $clog2(WMAX) + 1;

  localparam logic [LCW-1:0] HOLD      = LCW'(LOCK_HOLD);
  localparam logic [WCW-1:0] DRDY_LAST = WCW'(DRDY_TIMEOUT);
  localparam logic [WCW-1:0] LOCK_LAST = WCW'(LOCK_TIMEOUT - 1);

  drp_state_e     state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           sel_q, sel_d;
  logic           err_q, err_d;
  logic [15:0]    cap_q, cap_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  drp_entry_t     ent;

  // Looked up on the next index/select so the registered DRP outputs line up
  // with the state they belong to.
  ngb_mmcm_drp_rom u_rom (
    .sel   (sel_d),
    .idx   (idx_d),
    .entry (ent)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    err_d   = err_q;
    cap_d   = cap_q;
    wcnt_d  = '0;
    unique case (state_q)
      ST_IDLE: if (cfg_req) begin
        sel_d   = cfg_sel;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = ST_RST_ON;
      end
      ST_RST_ON: begin
        idx_d   = '0;
        state_d = ST_RD;
      end
      ST_RD: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (drp_drdy) begin
          cap_d   = drp_do;
          state_d = ST_WR;
        end else if (wcnt_q == DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RST_OFF;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_WR: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (drp_drdy) begin
          state_d = ST_NEXT;
        end else if (wcnt_q == DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RST_OFF;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_NEXT: begin
        if (idx_q == 3'd7) begin
          state_d = ST_RST_OFF;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_RD;
        end
      end
      ST_RST_OFF: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = ST_FINISH;
        end else if (wcnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Lock qualifier; RST_OFF also restarts it so a stale count from before the
  // reconfiguration can never satisfy WAIT_LOCK.
  always_comb begin
    lcnt_d = lcnt_q;
    if (!mmcm_locked || mmcm_rst || state_q == ST_RST_OFF) lcnt_d = '0;
    else if (lcnt_q != HOLD)                              lcnt_d = lcnt_q + LCW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
      cap_q     <= '0;
      wcnt_q    <= '0;
      lcnt_q    <= '0;
      lock_ok   <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
      mmcm_rst  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      cap_q    <= cap_d;
      wcnt_q   <= wcnt_d;
      lcnt_q   <= lcnt_d;
      lock_ok  <= (lcnt_d == HOLD);
      // Outputs decode the state being entered, so they are valid for exactly
      // the cycles spent in that state.
      cfg_busy <= (state_d != ST_IDLE);
      cfg_done <= (state_d == ST_FINISH);
      cfg_err  <= (state_d == ST_FINISH) && err_d;
      drp_den  <= (state_d == ST_RD) || (state_d == ST_WR);
      drp_dwe  <= (state_d == ST_WR);
      mmcm_rst <= (state_d inside {ST_RST_ON, ST_RD, ST_RD_WAIT, ST_WR, ST_WR_WAIT, ST_NEXT});
      if (state_d == ST_RD) drp_daddr <= ent.addr;
      if (state_d == ST_WR) drp_di    <= (cap_d & ent.mask) | (ent.data & ~ent.mask);
    end
  end

endmodule

// File: tb/tb_ngb_mmcm_drp_ctrl.sv
// Directed bench for ngb_mmcm_drp_ctrl with a DRP/MMCM behavioural model.
module tb_ngb_mmcm_drp_ctrl;

  logic        clk_in = 1'b0;
  logic        reset, cfg_req, cfg_sel;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst, mmcm_locked, lock_ok;

  ngb_mmcm_drp_ctrl dut (
    .clk_in(clk_in), .reset(reset), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked), .lock_ok(lock_ok)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- DRP / MMCM model ----------------
  logic [15:0] do_val = 16'hFFFF;
  int          miss_read = 0;      // absolute read number that never gets DRDY
  logic        lock_never = 1'b0;
  logic        drop_req = 1'b0;
  logic        drop_q = 1'b0;
  logic        locked_m = 1'b0;
  logic        miss_pend = 1'b0;
  int          pend = 0;
  int          rd_seen = 0;
  int          rel = 0;

  assign mmcm_locked = locked_m & ~drop_q;

  always @(posedge clk_in) begin
    drp_drdy <= 1'b0;
    if (pend == 1) begin
      drp_drdy <= ~miss_pend;
      drp_do   <= do_val;
      pend     <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end
    if (drp_den) begin
      pend <= 3;
      if (!drp_dwe) begin
        rd_seen   <= rd_seen + 1;
        miss_pend <= (rd_seen + 1 == miss_read);
      end else begin
        miss_pend <= 1'b0;
      end
    end
    drop_q <= drop_req;
    if (mmcm_rst) begin
      locked_m <= 1'b0;
      rel      <= 0;
    end else if (!locked_m && !lock_never) begin
      if (rel == 49) locked_m <= 1'b1;
      else           rel <= rel + 1;
    end
  end

  // ---------------- monitor ----------------
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_done_cnt = 0, stray_err = 0, overlap = 0;
  int rd_cyc_last = 0, rst_fall_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0;
  int lockok_rise_cyc = 0, lockok_fall_cyc = 0, done_cyc = 0;
  logic [6:0]  wr_addr_q[$];
  logic [15:0] wr_di_q[$];
  logic outst = 1'b0, rst_prev = 1'b0, lk_prev = 1'b0, ok_prev = 1'b0;

  always @(negedge clk_in) begin
    #1;
    if (!cfg_busy) outst = 1'b0;
    if (drp_den) begin
      if (outst) overlap++;
      outst = 1'b1;
      if (drp_dwe) begin
        wr_cnt++;
        wr_addr_q.push_back(drp_daddr);
        wr_di_q.push_back(drp_di);
      end else begin
        rd_cnt++;
        rd_cyc_last = cyc;
      end
    end
    if (drp_drdy) outst = 1'b0;
    if (rst_prev && !mmcm_rst)    rst_fall_cyc    = cyc;
    if (!lk_prev && mmcm_locked)  lock_rise_cyc   = cyc;
    if (lk_prev && !mmcm_locked)  lock_fall_cyc   = cyc;
    if (!ok_prev && lock_ok)      lockok_rise_cyc = cyc;
    if (ok_prev && !lock_ok)      lockok_fall_cyc = cyc;
    if (cfg_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (cfg_err) err_done_cnt++;
    end else if (cfg_err) begin
      stray_err++;
    end
    rst_prev = mmcm_rst;
    lk_prev  = mmcm_locked;
    ok_prev  = lock_ok;
  end

  // ---------------- expected tables (hand computed) ----------------
  logic [6:0]  EXP_ADDR [8] = '{7'h08, 7'h09, 7'h0A, 7'h0C, 7'h0E, 7'h10, 7'h14, 7'h15};
  // profile 0, DO = FFFF : mask | data
  logic [15:0] P0_FFFF [8] = '{16'h1104, 16'hFC00, 16'h10C2, 16'h10C3, 16'h1659, 16'h1145, 16'h1145, 16'hFC00};
  // profile 1, DO = 5A5A : reg1 keeps bit12=1, reg2 keeps 5A5A&FC00=5800
  logic [15:0] P1_5A5A [8] = '{16'h1145, 16'h5800, 16'h1082, 16'h1104, 16'h1514, 16'h128A, 16'h1145, 16'h5800};
  // profile 0, DO = 0000 : data & ~mask
  logic [15:0] P0_0000 [8] = '{16'h0104, 16'h0000, 16'h00C2, 16'h00C3, 16'h0659, 16'h0145, 16'h0145, 16'h0000};

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic start_cfg(input logic sel);
    cfg_sel = sel;
    cfg_req = 1'b1;
    step();
    cfg_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int w0, r0, d0, e0;
    reset = 1'b1; cfg_req = 1'b0; cfg_sel = 1'b0;
    steps(3);
    // reset state
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_den", drp_den, 0);
    chk("rst_dwe", drp_dwe, 0);
    chk("rst_mmcm_rst", mmcm_rst, 0);
    chk("rst_lock_ok", lock_ok, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_di", drp_di, 0);
    reset = 1'b0;
    steps(2);

    // ---- profile 0 full run, DO=FFFF ----
    do_val = 16'hFFFF;
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_done_cnt;
    start_cfg(1'b0);
    chk("t1_busy_on_accept", cfg_busy, 1);
    chk("t1_mmcm_rst_on", mmcm_rst, 1);
    wait_done(3000, "t1_done_timeout");
    steps(10);
    chk("t1_reads", rd_cnt - r0, 8);
    chk("t1_writes", wr_cnt - w0, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_addr%0d", i), wr_addr_q[w0 + i], EXP_ADDR[i]);
      chk($sformatf("t1_di%0d", i), wr_di_q[w0 + i], P0_FFFF[i]);
    end
    chk("t1_single_done", done_cnt - d0, 1);
    chk("t1_no_err", err_done_cnt - e0, 0);
    chk("t1_lock_hold", lockok_rise_cyc - lock_rise_cyc, 200);
    chk("t1_busy_off", cfg_busy, 0);
    chk("t1_overlap", overlap, 0);

    // ---- lock loss in IDLE ----
    chk("t2_lock_ok_before", lock_ok, 1);
    w0 = wr_cnt; r0 = rd_cnt;
    drop_req = 1'b1;
    step();
    drop_req = 1'b0;
    step();
    chk("t2_lock_ok_low", lock_ok, 0);
    chk("t2_drop_latency", lockok_fall_cyc - lock_fall_cyc, 1);
    steps(220);
    chk("t2_lock_ok_back", lock_ok, 1);
    chk("t2_relock_hold", lockok_rise_cyc - lock_rise_cyc, 200);
    chk("t2_no_drp", (rd_cnt - r0) + (wr_cnt - w0), 0);
    chk("t2_busy", cfg_busy, 0);

    // ---- DRDY missing on 3rd read ----
    miss_read = rd_seen + 3;
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_done_cnt;
    start_cfg(1'b0);
    wait_done(3000, "t3_done_timeout");
    steps(10);
    miss_read = 0;
    chk("t3_reads", rd_cnt - r0, 3);
    chk("t3_writes", wr_cnt - w0, 2);
    chk("t3_drdy_timeout", rst_fall_cyc - rd_cyc_last, 257);
    chk("t3_single_done", done_cnt - d0, 1);
    chk("t3_err_with_done", err_done_cnt - e0, 1);
    chk("t3_stray_err", stray_err, 0);

    // ---- second request during 5th write is ignored ----
    begin
      logic pulsed = 1'b0;
      int n = 0;
      do_val = 16'h5A5A;
      w0 = wr_cnt; d0 = done_cnt; e0 = err_done_cnt;
      start_cfg(1'b1);
      while (done_cnt == d0 && n < 3000) begin
        if (!pulsed && wr_cnt - w0 == 5) begin
          cfg_sel = 1'b0;
          cfg_req = 1'b1;
          pulsed  = 1'b1;
          step();
          cfg_req = 1'b0;
        end else begin
          step();
        end
        n++;
      end
      chk("t4_pulsed", pulsed, 1);
      steps(30);
      chk("t4_single_done", done_cnt - d0, 1);
      chk("t4_no_err", err_done_cnt - e0, 0);
      chk("t4_writes", wr_cnt - w0, 8);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t4_addr%0d", i), wr_addr_q[w0 + i], EXP_ADDR[i]);
        chk($sformatf("t4_di%0d", i), wr_di_q[w0 + i], P1_5A5A[i]);
      end
    end

    // ---- reset while in WR_WAIT, then a fresh run ----
    begin
      int n = 0;
      w0 = wr_cnt; d0 = done_cnt; e0 = err_done_cnt;
      start_cfg(1'b1);
      while (wr_cnt - w0 < 3 && n < 1000) begin
        step();
        n++;
      end
      chk("t5_reached_wr", wr_cnt - w0, 3);
      step();                    // now in WR_WAIT
      reset = 1'b1;
      step();
      chk("t5_mmcm_rst", mmcm_rst, 0);
      chk("t5_den", drp_den, 0);
      chk("t5_busy", cfg_busy, 0);
      reset = 1'b0;
      steps(10);
      do_val = 16'h0000;
      w0 = wr_cnt;
      start_cfg(1'b0);
      wait_done(3000, "t5_done_timeout");
      steps(10);
      chk("t5_writes", wr_cnt - w0, 8);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t5_addr%0d", i), wr_addr_q[w0 + i], EXP_ADDR[i]);
        chk($sformatf("t5_di%0d", i), wr_di_q[w0 + i], P0_0000[i]);
      end
      chk("t5_single_done", done_cnt - d0, 1);
      chk("t5_no_err", err_done_cnt - e0, 0);
    end

    // ---- LOCKED never returns ----
    lock_never = 1'b1;
    d0 = done_cnt; e0 = err_done_cnt;
    start_cfg(1'b1);
    wait_done(70000, "t6_done_timeout");
    // RST_OFF, then 65535 cycles in WAIT_LOCK, then the FINISH pulse
    chk("t6_lock_timeout", done_cyc - rst_fall_cyc, 65536);
    chk("t6_err_with_done", err_done_cnt - e0, 1);
    steps(5);
    chk("t6_single_done", done_cnt - d0, 1);
    chk("t6_stray_err", stray_err, 0);
    chk("t6_lock_ok", lock_ok, 0);
    chk("all_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ngb_mmcm_drp_ctrl.md
NGB_MMCM_DRP_CTRL -- requirements
Module: ngb_mmcm_drp_ctrl

Interface
REQ-001 Parameter LOCK_HOLD, default 200: number of consecutive cycles with LOCKED high before lock_ok asserts.
REQ-002 Parameter DRDY_TIMEOUT, default 255: maximum wait cycles for drp_drdy per DRP access.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum wait cycles for relock after mmcm_rst release.
REQ-004 Port clk_in, input, 1: the single clock; it also drives DCLK.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port cfg_req, input, 1: one-cycle reconfiguration request.
REQ-007 Port cfg_sel, input, 1: profile select, 0 or 1.
REQ-008 Port cfg_busy, output, 1: high from acceptance until done.
REQ-009 Port cfg_done, output, 1: one-cycle completion pulse.
REQ-010 Port cfg_err, output, 1: one-cycle pulse, coincident with cfg_done on failure.
REQ-011 Port drp_daddr, output, 7: MMCM DADDR.
REQ-012 Port drp_den / drp_dwe, output, 1 each: MMCM DEN / DWE.
REQ-013 Port drp_di, output, 16: MMCM DI.
REQ-014 Port drp_do, input, 16: MMCM DO.
REQ-015 Port drp_drdy, input, 1: MMCM DRDY.
REQ-016 Port mmcm_rst, output, 1: drives MMCM RST.
REQ-017 Port mmcm_locked, input, 1: MMCM LOCKED.
REQ-018 Port lock_ok, output, 1: qualified lock, used to gate the downstream per-domain reset chains.

Function
REQ-019 States: IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_OFF, WAIT_LOCK, FINISH.
REQ-020 IDLE: cfg_req=1 -> latch cfg_sel, cfg_busy=1, go to RST_ON; cfg_req while busy is ignored (no queueing).
REQ-021 RST_ON: assert mmcm_rst, entry index=0, go to RD; mmcm_rst stays high through NEXT.
REQ-022 RD: one-cycle drp_den=1, drp_dwe=0, drp_daddr=entry address; go to RD_WAIT.
REQ-023 RD_WAIT: on drp_drdy, capture drp_do and go to WR.
REQ-024 WR: one-cycle drp_den=1, drp_dwe=1, same address, drp_di=(captured & mask) | (data & ~mask); mask bit 1 means keep the old bit. Go to WR_WAIT.
REQ-025 WR_WAIT: on drp_drdy, go to NEXT.
REQ-026 NEXT: if index=7, go to RST_OFF; else index+1 and go to RD. Index is 3 bits; no wrap is used.
REQ-027 Each profile has exactly 8 entries, each {addr[6:0], mask[15:0], data[15:0]}.
REQ-028 RST_OFF: deassert mmcm_rst, clear the lock counter, go to WAIT_LOCK.
REQ-029 WAIT_LOCK: go to FINISH when lock_ok=1.
REQ-030 FINISH: one-cycle cfg_done=1, cfg_busy=0 on the following cycle, return to IDLE.
REQ-031 drdy timeout: the wait counter exceeds DRDY_TIMEOUT in RD_WAIT or WR_WAIT -> go to RST_OFF with an error flag set.
REQ-032 Lock timeout: LOCK_TIMEOUT cycles in WAIT_LOCK without lock_ok -> go to FINISH with the error flag set.
REQ-033 Error termination: FINISH pulses cfg_err together with cfg_done.
REQ-034 Partial writes already completed are not rolled back.
REQ-035 drp_drdy outside RD_WAIT and WR_WAIT is ignored.
REQ-036 drp_den is never asserted while a prior access is outstanding.
REQ-037 Lock monitor runs in all states.
  - Counter cleared when mmcm_locked=0 or mmcm_rst=1.
  - Otherwise increments, saturating at LOCK_HOLD.
  - lock_ok is registered: 1 when counter = LOCK_HOLD.
  - Drops 1 cycle after mmcm_locked falls.
REQ-038 Lock loss in IDLE drops lock_ok only; no automatic reconfiguration.
REQ-039 Counter widths: lock counter and timeout counter sized by $clog2 of their parameter + 1.

Reset
REQ-040 During reset, state returns to IDLE regardless of the current state, including mid-DRP.
REQ-041 Reset values: cfg_busy, cfg_done, cfg_err, drp_den, drp_dwe, mmcm_rst, lock_ok = 0; drp_daddr, drp_di = 0.
REQ-042 Reset values: index, all counters and the error flag = 0.
REQ-043 All outputs are registered.

Structure
REQ-044 Shared package ngb_clk_pkg holds:
  - the state enumeration;
  - the DRP entry record type {addr, mask, data};
  - the profile table constants: profile 0 = current 125/200/166/20/100 MHz set, profile 1 = alternate.
REQ-045 One sub-module, ngb_mmcm_drp_rom: combinational lookup of {sel, index} -> entry.

Verification
REQ-046 Profile 0 request; DRP model returns DO=16'hFFFF with DRDY after 3 cycles; LOCKED after 50 cycles -> 8 reads and 8 writes, each drp_di=(FFFF&mask)|(data&~mask); lock_ok 200 cycles after LOCKED; single cfg_done with cfg_err=0.
REQ-047 DRDY never returned on the 3rd read -> after 256 wait cycles mmcm_rst falls, then WAIT_LOCK; cfg_done and cfg_err pulse together; only 2 writes issued.
REQ-048 cfg_req pulsed again at the 5th write -> ignored; exactly one cfg_done; entries 0-7 each written once.
REQ-049 LOCKED drops for 1 cycle in IDLE -> lock_ok low the next cycle, high again 200 cycles after LOCKED returns; no DRP activity.
REQ-050 reset asserted in WR_WAIT -> next cycle mmcm_rst=0, drp_den=0, cfg_busy=0; a fresh cfg_req after reset runs from entry 0.
REQ-051 LOCKED never returns -> cfg_err and cfg_done pulse 65535 cycles after RST_OFF.
